mac_dot_sequencer: RTL
======================

# mac_dot_sequencer

Sequencing controller for the 16-bit low-power MAC datapath: accepts a vector length and a start command, streams operand pairs in over a valid/ready handshake, and drives them through the shared 16x16 Vedic multiplier and a 35-bit accumulator. It asserts a one-cycle `done` with the dot product and an overflow flag. It sits between the operand source (memory reader or testbench) and the result consumer, and replaces manual `en`/`clr` driving of the bare MAC.

## Interface
- `LEN_W`, default 8: width of the vector-length field; maximum length is 2^LEN_W-1.
- `ACC_W`, default 35: accumulator width. Fixed at 35 to match the MAC output.
- `clk`  in  1: single clock; all state updates on rising edge.
- `clr`  in  1: reset, asynchronous, active-high; forces all state to reset values immediately.
- `start`  in  1: begin a dot product. Sampled only in IDLE.
- `len`  in  LEN_W: number of operand pairs. Sampled with `start`.
- `a_in`, `b_in`  in  16 each: unsigned operands.
- `in_valid`  in  1: operand pair present.
- `in_ready`  out  1: sequencer will accept a pair this cycle.
- `acc_out`  out  35: accumulator register, unsigned.
- `done`  out  1: one-cycle pulse; `acc_out`/`ovf` final.
- `busy`  out  1: high in every state except IDLE.
- `ovf`  out  1: sticky; accumulation exceeded 2^35-1 during this job.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `in_ready`=0.
  - `start`=1 and `len`≠0: load `cnt`←`len`, clear `acc`/`ovf`/`prod_v`, go to RUN.
  - `start`=1 and `len`=0: clear `acc`/`ovf`, go to DONE.
- RUN:
  - `in_ready`=1.
  - Handshake (`in_valid`&`in_ready`): `prod_q`←`a_in`*`b_in` (32-bit), `prod_v`←1, `cnt`←`cnt`-1. Otherwise `prod_v`←0.
  - Every cycle with `prod_v`=1: `acc`←`acc`+{3'b0,`prod_q`}.
  - Handshake with `cnt`=1: go to DRAIN.
- DRAIN: `in_ready`=0; adds the final `prod_q`; go to DONE.
- DONE: `done`=1 for exactly one cycle; go to IDLE. `acc_out`/`ovf` hold until the next accepted `start`.
- Arithmetic is unsigned. The 36-bit sum carry-out sets `ovf` (sticky). Result handling on overflow follows Configuration.
- `start` outside IDLE is ignored; `len` and operands outside a handshake are ignored.
- `in_valid` bubbles in RUN insert no products and do not change the result.

## Timing
- Reset values: `in_ready`=0, `acc_out`=0, `done`=0, `busy`=0, `ovf`=0, state IDLE, `cnt`=0, `prod_v`=0.
- `clr` mid-job aborts immediately: no `done` is produced and the partial result is discarded.
- Multiply stage latency is 1 edge; accumulate stage latency is 1 edge.
- `done` is high in the 2nd cycle after the edge on which the last pair handshook.
- `len`=0: `done` is high the cycle after the `start` edge, with `acc_out`=0.
- Throughput: one pair per cycle. Job duration is `len`+2 cycles after start with no bubbles.
- `in_ready` is a function of state only; it has no combinational path from `in_valid`.

## Configuration
- `MAC_SAT_EN` defined: on carry-out, `acc` clamps to 35'h7_FFFF_FFFF and stays there for the rest of the job; `ovf`=1.
- `MAC_SAT_EN` undefined: `acc` wraps modulo 2^35; `ovf`=1 all the same.

## Structure
- Package `mac_pkg`:
  - state enum (IDLE/RUN/DRAIN/DONE)
  - `OP_W`=16, `PROD_W`=32, `ACC_W`=35
  - `ACC_MAX` saturation constant
- Sub-module: the existing `vedic_16x16`, instantiated once as the combinational multiplier feeding `prod_q`. There is no other hierarchy.

## Test plan
- `len`=1, pair (3,4) → `done` with `acc_out`=12, `ovf`=0; `busy` falls the cycle after `done`.
- `len`=4, pairs (1,1),(2,2),(3,3),(4,4), streamed back-to-back → `acc_out`=30; `done` exactly 2 cycles after the 4th handshake edge.
- Same 4 pairs with random `in_valid` gaps, plus `start` pulsed during RUN → `acc_out`=30 and only one `done`.
- `len`=0 → `done` the cycle after start, `acc_out`=0, `in_ready` never high.
- `len`=9, all pairs (16'hFFFF,16'hFFFF) → `ovf`=1; with `MAC_SAT_EN` `acc_out`=35'h7_FFFF_FFFF, without it `acc_out`=35'h0_FFEE_0009.
- `clr` pulsed mid-RUN after 2 of 4 pairs → outputs at reset values asynchronously; a new `len`=2 job (5,6),(7,8) then gives `acc_out`=86 with `ovf`=0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared widths, state encoding and saturation constant for the MAC dot-product sequencer.
// The MAC_SAT_EN macro selects saturating accumulation in mac_dot_sequencer.
package mac_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;
  localparam int ACC_W  = 35;

  localparam logic [ACC_W-1:0] ACC_MAX = 35'h7_FFFF_FFFF;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/vedic_16x16.sv
// Combinational 16x16 unsigned multiplier, Vedic (Urdhva) split into four 8x8 partial products.
module vedic_16x16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  logic [15:0] ll;
  logic [15:0] lh;
  logic [15:0] hl;
  logic [15:0] hh;
  logic [16:0] mid;

  assign ll  = {8'b0, a[7:0]}  * {8'b0, b[7:0]};
  assign lh  = {8'b0, a[7:0]}  * {8'b0, b[15:8]};
  assign hl  = {8'b0, a[15:8]} * {8'b0, b[7:0]};
  assign hh  = {8'b0, a[15:8]} * {8'b0, b[15:8]};
  assign mid = {1'b0, lh} + {1'b0, hl};

  // Cross terms sit 8 bits up; the outer terms concatenate without overlap.
  assign p = {hh, ll} + {7'b0, mid, 8'b0};

endmodule

// File: rtl/mac_dot_sequencer.sv
// Dot-product sequencer: streams operand pairs through vedic_16x16 into a 35-bit accumulator.
// Define MAC_SAT_EN for saturating accumulation; otherwise the accumulator wraps.
module mac_dot_sequencer #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 35
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      a_in,
  input  logic [15:0]      b_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             done,
  output logic             busy,
  output logic             ovf
);

  import mac_pkg::*;

  state_t            state;
  logic [LEN_W-1:0]  cnt;
  logic [PROD_W-1:0] prod_q;
  logic [PROD_W-1:0] prod_w;
  logic              prod_v;
  logic [ACC_W-1:0]  acc;
  logic              ovf_q;
  logic [ACC_W:0]    sum;
  logic              carry;
  logic [ACC_W-1:0]  acc_nxt;
  logic              hs;

  vedic_16x16 u_mul (
    .a (a_in),
    .b (b_in),
    .p (prod_w)
  );

  // in_ready depends on state alone so the source never sees a loop through in_valid.
  assign in_ready = (state == ST_RUN);
  assign hs       = in_valid & in_ready;
  assign sum      = {1'b0, acc} + (ACC_W + 1)'(prod_q);
  assign carry    = sum[ACC_W];

  // NOTE: assign a default before any branch so always_comb never infers a latch.
  always_comb begin
    acc_nxt = sum[ACC_W-1:0];
`ifdef MAC_SAT_EN
    if (carry || ovf_q) acc_nxt = ACC_MAX;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      prod_q <= '0;
      prod_v <= 1'b0;
      acc    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (prod_v) begin
        acc   <= acc_nxt;
        ovf_q <= ovf_q | carry;
      end
      case (state)
        ST_IDLE: begin
          prod_v <= 1'b0;
          if (start) begin
            acc   <= '0;
            ovf_q <= 1'b0;
            if (len != '0) begin
              cnt   <= len;
              state <= ST_RUN;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (hs) begin
            prod_q <= prod_w;
            prod_v <= 1'b1;
            cnt    <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) state <= ST_DRAIN;
          end else begin
            prod_v <= 1'b0;
          end
        end
        ST_DRAIN: begin
          prod_v <= 1'b0;
          state  <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign acc_out = acc;
  assign ovf     = ovf_q;
  assign done    = (state == ST_DONE);
  assign busy    = (state != ST_IDLE);

endmodule
